sort6_seq_engine: RTL and testbench
===================================

Name: sort6_seq_engine

Overview:
- Sequential sorter for COUNT unsigned N-bit words, default 6 words of 8 bits.
- Sits directly downstream of the width-parameterised magnitude comparator: instantiates exactly one comparator and uses its l/e/g outputs to drive a bubble-sort compare-swap datapath.
- Loads words over a valid/ready stream, sorts in place in a register file, then streams the sorted words out over a valid/ready interface with a last marker.

Parameters:
- N, 8, data word width in bits, also passed to the comparator instance.
- COUNT, 6, number of words per sort batch; legal range 2..16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  engine can accept a word; registered.
- in_data  input  N  unsigned input word.
- out_valid  output  1  sorted word valid; registered.
- out_ready  input  1  downstream accepts the word.
- out_data  output  N  sorted word.
- out_last  output  1  high with the final word of a batch.
- busy  output  1  high in SORT or OUT.

Behaviour:
- One clock. Reset is asynchronous, active-low. While rst_n=0:
  - state=LOAD, all counters=0, all word registers=0.
  - in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0.
- in_ready goes to 1 on the first rising edge after rst_n releases.
- An asserted rst_n=0 in any state aborts the batch immediately. Partially loaded or sorted data is discarded.
- FSM states: LOAD, SORT, OUT.
- LOAD:
  - A word is accepted on an edge where in_valid and in_ready are both high.
  - The word is written to reg[wr_idx], then wr_idx increments.
  - On the edge accepting word COUNT-1, in_ready clears to 0, wr_idx returns to 0, and the state moves to SORT.
  - in_valid with in_ready=0 is ignored. No data is latched.
- SORT:
  - Two counters: pass p runs 0..COUNT-2; index j runs 0..COUNT-2-p.
  - Each cycle the comparator sees a=reg[j] and b=reg[j+1].
  - If g=1, the two registers swap on the clock edge. If l=1 or e=1, no swap; equal values are never swapped, so the sort is stable.
  - j increments. When j reaches COUNT-2-p, j resets to 0 and p increments.
  - The final compare is p=COUNT-2, j=0. After it, the state moves to OUT.
  - No early exit. SORT always takes COUNT*(COUNT-1)/2 cycles (15 for COUNT=6).
- OUT:
  - out_valid=1 and out_data=reg[rd_idx], starting at rd_idx=0.
  - On an edge where out_valid and out_ready are both high, rd_idx increments.
  - out_last=1 exactly when rd_idx=COUNT-1.
  - On the handshake of the last word: out_valid=0, rd_idx=0, state moves to LOAD, and in_ready is set to 1 on the same edge.
  - out_ready low stalls indefinitely. out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Latency, with the last input accepted on edge E0:
  - SORT occupies the cycles following E0 through E0+15.
  - out_valid rises on edge E0+15 (COUNT=6).
  - For general COUNT, out_valid rises on edge E0+COUNT*(COUNT-1)/2.
- busy is combinational: 1 in SORT or OUT.
- Arithmetic: pure unsigned compare, no arithmetic on data. Counters are $clog2(COUNT) bits wide. Counters never wrap past their terminal values.
- No overlap between batches. A new batch is accepted only after the last output handshake.

Optional Feature:
- Macro SORT_DESCEND_EN.
- Defined: the swap condition becomes l=1, so output is in descending order. Equal values are still not swapped, so the sort stays stable.
- Undefined: the swap condition is g=1, giving ascending order. Cycle timing is identical in both builds.

Test Plan:
- Reset mid-SORT: load 6 words, assert rst_n=0 at the 7th SORT cycle → all outputs immediately 0. After release, in_ready=1 and a fresh batch 1,2,3,4,5,6 outputs 1..6 in order.
- Reverse input: load 200,150,100,50,25,0 with out_ready=1 → out_valid rises exactly 15 edges after the last input accept. Output is 0,25,50,100,150,200 on 6 consecutive cycles, out_last only on 200.
- Duplicates and extremes: load 255,0,7,7,255,0 → output 0,0,7,7,255,255. In the SORT_DESCEND_EN build → 255,255,7,7,0,0.
- Backpressure: during OUT, toggle out_ready 1,0,0,1,0,1… → each word is presented until accepted, with no drops or repeats. out_data holds while stalled. busy=1 until the final handshake.
- Input gating: hold in_valid=1 with a changing in_data through SORT and OUT → no words latched, and the next batch loads cleanly. in_ready=1 on the same edge as the final output handshake, so back-to-back batches have no idle cycle.

Source files
------------

// File: rtl/sort6_seq_engine.sv
// Bubble-sort engine: loads COUNT words, sorts in place using one magnitude comparator, streams result with last marker.
// Latency: out_valid rises COUNT*(COUNT-1)/2 edges after the final input accept; SORT_DESCEND_EN selects descending order.
// Backpressure: in_ready low outside LOAD; out_ready low stalls OUT indefinitely with out_data/out_last held.

module sort6_mag_cmp #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         l,
    output logic         e,
    output logic         g
);
    assign l = (a < b);
    assign e = (a == b);
    assign g = (a > b);
endmodule

module sort6_seq_engine #(
    parameter int N     = 8,
    parameter int COUNT = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy
);
    localparam int CW = $clog2(COUNT);

    typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_OUT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wr_idx_q, wr_idx_d;
    logic [CW-1:0]   rd_idx_q, rd_idx_d;
    logic [CW-1:0]   p_q, p_d;
    logic [CW-1:0]   j_q, j_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    regs_q [COUNT];
    logic [N-1:0]    regs_d [COUNT];

    logic [CW-1:0]   j_nxt;
    logic [CW-1:0]   j_last;
    logic            cmp_l, cmp_e, cmp_g;
    logic            swap;

    assign j_nxt  = j_q + 1'b1;
    assign j_last = CW'(COUNT - 2) - p_q;

    sort6_mag_cmp #(.N(N)) u_cmp (
        .a (regs_q[j_q]),
        .b (regs_q[j_nxt]),
        .l (cmp_l),
        .e (cmp_e),
        .g (cmp_g)
    );

    // Equal words never swap in either direction, keeping the sort stable.
`ifdef SORT_DESCEND_EN
    assign swap = cmp_l;
`else
    assign swap = cmp_g;
`endif

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        p_d         = p_q;
        j_d         = j_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        regs_d      = regs_q;
        case (state_q)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    regs_d[wr_idx_q] = in_data;
                    if (wr_idx_q == CW'(COUNT - 1)) begin
                        wr_idx_d   = '0;
                        in_ready_d = 1'b0;
                        state_d    = ST_SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            ST_SORT: begin
                if (swap) begin
                    regs_d[j_q]   = regs_q[j_nxt];
                    regs_d[j_nxt] = regs_q[j_q];
                end
                if (j_q == j_last) begin
                    j_d = '0;
                    if (p_q == CW'(COUNT - 2)) begin
                        p_d         = '0;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end else begin
                    j_d = j_nxt;
                end
            end
            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    if (rd_idx_q == CW'(COUNT - 1)) begin
                        rd_idx_d    = '0;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = ST_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_LOAD;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            p_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            p_q         <= p_d;
            j_q         <= j_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            regs_q      <= regs_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? regs_q[rd_idx_q] : '0;
    assign out_last  = out_valid_q && (rd_idx_q == CW'(COUNT - 1));
    assign busy      = (state_q == ST_SORT) || (state_q == ST_OUT);

endmodule

// File: tb/tb_sort6_seq_engine.sv
// Randomised and directed bench for sort6_seq_engine, checked against a queue-sort reference model.
module tb_sort6_seq_engine;
    localparam int N     = 8;
    localparam int COUNT = 6;
    localparam int SORT_CYC = COUNT * (COUNT - 1) / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int e0     = 0;

    sort6_seq_engine #(.N(N), .COUNT(COUNT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_sort(input int v[COUNT], output int r[COUNT]);
        int q[$];
        foreach (v[i]) q.push_back(v[i]);
`ifdef SORT_DESCEND_EN
        q.rsort();
`else
        q.sort();
`endif
        foreach (r[i]) r[i] = q[i];
    endfunction

    // Drives one word per accepted handshake; returns on the negedge after the final accept.
    task automatic load_batch(input int v[COUNT], input bit keep_valid);
        for (int i = 0; i < COUNT; i++) begin
            int t = 0;
            in_valid = 1'b1;
            in_data  = v[i][N-1:0];
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) check("in_ready_timeout", 0, 1);
            @(negedge clk);
        end
        e0 = cyc;
        if (keep_valid) in_data = N'($urandom);
        else in_valid = 1'b0;
        check("load_in_ready", in_ready, 0);
        check("load_busy", busy, 1);
    endtask

    // mode 0: always ready, 1: fixed toggle pattern, 2: random ready
    task automatic read_batch(input int mode, input int exp[COUNT], input bit gate, input bit chk_lat);
        int t = 0;
        int got = 0;
        int guard = 0;
        bit pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b0;
        while (!out_valid && t < 200) begin
            if (gate) begin
                check("gate_sort_in_ready", in_ready, 0);
                in_data = N'($urandom);
            end
            @(negedge clk);
            t++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
        if (chk_lat) check("latency", cyc - e0, SORT_CYC);
        while (got < COUNT && guard < 500) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[guard % 6];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            check("out_valid", out_valid, 1);
            check("busy_out", busy, 1);
            check("out_data", out_data, exp[got]);
            check("out_last", out_last, (got == COUNT - 1));
            if (gate) begin
                check("gate_out_in_ready", in_ready, 0);
                in_data = N'($urandom);
            end
            if (out_ready) got++;
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        if (got < COUNT) check("out_timeout", got, COUNT);
        check("post_out_valid", out_valid, 0);
        check("post_busy", busy, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int v[COUNT];
        int r[COUNT];

        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);

        // Reset in the seventh SORT cycle, then a clean batch.
        v = '{9, 3, 8, 1, 6, 2};
        load_batch(v, 1'b0);
        repeat (6) @(negedge clk);
        check("mid_sort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_last", out_last, 0);
        check("abort_busy", busy, 0);
        check("abort_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rel_in_ready", in_ready, 1);
        v = '{1, 2, 3, 4, 5, 6};
        model_sort(v, r);
        load_batch(v, 1'b0);
        read_batch(0, r, 1'b0, 1'b1);

        // Reverse input, full-rate drain.
        v = '{200, 150, 100, 50, 25, 0};
        model_sort(v, r);
        load_batch(v, 1'b0);
        read_batch(0, r, 1'b0, 1'b1);

        // Duplicates and extremes under toggled backpressure.
        v = '{255, 0, 7, 7, 255, 0};
        model_sort(v, r);
        load_batch(v, 1'b0);
        read_batch(1, r, 1'b0, 1'b1);

        // in_valid held high with junk through SORT/OUT, then back-to-back batches.
        v = '{12, 250, 3, 99, 3, 180};
        model_sort(v, r);
        load_batch(v, 1'b1);
        read_batch(2, r, 1'b1, 1'b1);
        for (int b = 0; b < 8; b++) begin
            foreach (v[i]) v[i] = int'($urandom_range(0, (1 << N) - 1));
            if (b % 2 == 1) v[3] = v[1];
            model_sort(v, r);
            load_batch(v, 1'b1);
            read_batch(b % 3, r, 1'b1, 1'b1);
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
